unidad_control_param: RTL and testbench
=======================================

// Module: unidad_control_param
// PURPOSE
//  Clocked, parametrised successor of the 8-bit combinational control unit.
//  Decodes {op,src,dst} instructions against an internal register file.
//  Drives a 2*DATA_W output word plus zero and carry flags.
//  Accepts instructions through a valid/ready handshake, so a sequencer or bench can stall it.
//  Sits between the instruction source and the datapath output bus.
// PARAMETERS
//  DATA_W  8  width of registers, in_data and each half of out_data
//  REG_AW  3  register address field width; INSTR_W = 2 + 2*REG_AW
//             (default 8 bits: [7:6] op, [5:3] src, [2:0] dst)
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          synchronous, active-high reset
//  instr        in   INSTR_W    {op, src, dst}
//  instr_valid  in   1          instr present
//  instr_ready  out  1          block can accept instr this cycle
//  in_data      in   DATA_W     external operand; selected when src = all-ones
//  out_data     out  2*DATA_W   output register
//  zero         out  1          last result == 0
//  carry        out  1          carry out of last ADD
//  done         out  1          1-cycle pulse when any instruction retires
// BEHAVIOUR
//  - Registers R0..R(2^REG_AW-2). Index all-ones (ONES) is special:
//    - as src it reads in_data;
//    - as dst it writes out_data, zero-extended to 2*DATA_W.
//  - Operand S = (src==ONES) ? in_data : R[src]; sampled at acceptance.
//  - Accept = instr_valid & instr_ready at a rising clk edge.
//  - Ops:
//    - 00 LDI: dst <= zero-extend(src field).
//    - 01 ADD: dst <= D + S (mod 2^DATA_W); carry <= carry-out.
//      D = R[dst], or out_data[DATA_W-1:0] when dst==ONES.
//    - 10 MOV: dst <= S.
//    - 11 MUL: see CONFIGURATION.
//  - Single-cycle ops:
//    - result and flags visible the cycle after accept;
//    - done pulses that same cycle;
//    - instr_ready stays 1, giving back-to-back throughput of 1 per clk.
//  - zero <= (written value == 0) for every op. carry updates only on ADD/MUL.
//  - FSM: IDLE -> MUL_RUN -> MUL_WB -> IDLE.
//    - IDLE: instr_ready=1. Accepting a MUL goes to MUL_RUN and loads operands plus a count of DATA_W.
//    - MUL_RUN: instr_ready=0. Shift-add one bit per clk. Leaves after DATA_W cycles.
//    - MUL_WB: instr_ready=0. Writes back, pulses done, then returns to IDLE.
//    - MUL latency: accept-to-done = DATA_W+1 clks.
//  - instr_valid while not ready is ignored; the instr must be held until ready.
//  - Back-to-back hazard: an instr accepted the cycle after a write sees the updated value.
//  - Reset (any state, including mid-MUL) aborts the operation. Next cycle:
//    - all R = 0, out_data = 0;
//    - zero = 1, carry = 0, done = 0;
//    - instr_ready = 1, FSM = IDLE.
// CONFIGURATION
//  UNIDAD_MUL_EN defined:
//   - MUL: {out_data} <= D * S, the full 2*DATA_W product.
//   - R[dst] <= product low half, unless dst==ONES.
//   - carry <= |product high half.
//  UNIDAD_MUL_EN undefined:
//   - no multiplier and no MUL_RUN / MUL_WB states;
//   - op 11 retires in 1 cycle as a NOP (state unchanged, done pulses).
// TESTING
//  1. rst=1 for 2 clks -> out_data=0, zero=1, carry=0, instr_ready=1.
//  2. Register moves:
//     - LDI 8'b00_001_000 -> R0=1;
//     - MOV 8'b10_000_001 -> R1=1;
//     - in_data=8'hAA, MOV 8'b10_111_010 -> R2=8'hAA;
//     - MOV 8'b10_010_111 -> out_data=16'h00AA, zero=0.
//  3. R0=8'hFF, R1=1; ADD 8'b01_001_000 -> R0=0, carry=1, zero=1, done 1 clk later.
//  4. MUL_EN: R3=8'hFF, in_data=8'hFF, MUL 8'b11_111_011 ->
//     - instr_ready low 9 clks;
//     - out_data=16'hFE01, R3=8'h01, carry=1.
//  5. MUL_EN: assert rst 3 clks into a MUL -> all outputs at reset values, instr_ready=1 next clk.
//  6. 4 back-to-back MOVs with instr_valid held high -> 4 done pulses in 4 consecutive clks.

Source files
------------

// File: rtl/unidad_control_param.sv
// Clocked register-file control unit: decodes {op,src,dst}, 1-cycle LDI/ADD/MOV, valid/ready intake.
// Optional shift-add MUL (DATA_W+1 clk accept-to-done) when UNIDAD_MUL_EN is defined.
`default_nettype none

module unidad_control_param #(
  parameter  int DATA_W  = 8,
  parameter  int REG_AW  = 3,
  localparam int INSTR_W = 2 + 2*REG_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic [2*DATA_W-1:0]   out_data,
  output logic                  zero,
  output logic                  carry,
  output logic                  done
);

  localparam int                NREG   = (1 << REG_AW) - 1;
  localparam logic [REG_AW-1:0] ONES   = '1;
  localparam logic [1:0]        OP_LDI = 2'd0;
  localparam logic [1:0]        OP_ADD = 2'd1;
  localparam logic [1:0]        OP_MOV = 2'd2;
  localparam logic [1:0]        OP_MUL = 2'd3;

  logic [DATA_W-1:0] regs [NREG];

  logic [1:0]        op;
  logic [REG_AW-1:0] src;
  logic [REG_AW-1:0] dst;
  logic [DATA_W-1:0] s_val;
  logic [DATA_W-1:0] d_val;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] wr_val;
  logic              accept;
  logic              is_wr;

  assign op     = instr[INSTR_W-1 -: 2];
  assign src    = instr[2*REG_AW-1 -: REG_AW];
  assign dst    = instr[REG_AW-1:0];
  // index ONES never touches the register array: it aliases in_data / out_data
  assign s_val  = (src == ONES) ? in_data : regs[src];
  assign d_val  = (dst == ONES) ? out_data[DATA_W-1:0] : regs[dst];
  assign sum    = {1'b0, d_val} + {1'b0, s_val};
  assign accept = instr_valid & instr_ready;
  assign is_wr  = accept & (op != OP_MUL);

  always_comb begin
    wr_val = '0;
    case (op)
      OP_LDI:  wr_val = {{(DATA_W-REG_AW){1'b0}}, src};
      OP_ADD:  wr_val = sum[DATA_W-1:0];
      OP_MOV:  wr_val = s_val;
      default: wr_val = '0;
    endcase
  end

`ifdef UNIDAD_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_WB} state_t;

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] prod_nxt;
  logic [DATA_W-1:0]   mplier;
  logic [REG_AW-1:0]   mul_dst;
  logic                mul_last;

  assign prod_nxt = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && op == OP_MUL) state_nxt = MUL_RUN;
      end
      MUL_RUN: if (mul_last) state_nxt = MUL_WB;
      MUL_WB:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign instr_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      out_data <= '0;
      zero     <= 1'b1;
      carry    <= 1'b0;
      done     <= 1'b0;
`ifdef UNIDAD_MUL_EN
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mul_dst  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (is_wr) begin
        if (dst == ONES) out_data  <= {{DATA_W{1'b0}}, wr_val};
        else             regs[dst] <= wr_val;
        zero <= (wr_val == '0);
        if (op == OP_ADD) carry <= sum[DATA_W];
        done <= 1'b1;
      end
`ifdef UNIDAD_MUL_EN
      if (accept && op == OP_MUL) begin
        acc     <= '0;
        mcand   <= {{DATA_W{1'b0}}, d_val};
        mplier  <= s_val;
        mul_dst <= dst;
        cnt     <= CNT_W'(DATA_W);
      end
      if (state == MUL_RUN) begin
        acc    <= prod_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CNT_W'(1);
        // final partial sum is written back directly so done lands in MUL_WB
        if (mul_last) begin
          out_data <= prod_nxt;
          if (mul_dst != ONES) regs[mul_dst] <= prod_nxt[DATA_W-1:0];
          carry <= |prod_nxt[2*DATA_W-1:DATA_W];
          zero  <= (prod_nxt == '0);
          done  <= 1'b1;
        end
      end
`else
      if (accept && op == OP_MUL) done <= 1'b1;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unidad_control_param.sv
// Bench for unidad_control_param: directed spec scenarios plus random instructions vs. an arithmetic model.
`timescale 1ns/1ps

module tb_unidad_control_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  in_data;
  logic [15:0] out_data;
  logic        zero;
  logic        carry;
  logic        done;

  int tests = 0;
  int fails = 0;

  // reference state: index 7 unused (aliases in_data/out_data)
  int m_r [8];
  int m_out;
  int m_zero;
  int m_carry;

  always #5 clk = ~clk;

  unidad_control_param dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .in_data(in_data), .out_data(out_data),
    .zero(zero), .carry(carry), .done(done)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_out = 0; m_zero = 1; m_carry = 0;
  endtask

  task automatic model_exec(input logic [7:0] ins, input logic [7:0] d);
    int op, src, dst, s, dd, v, p;
    op  = int'(ins[7:6]);
    src = int'(ins[5:3]);
    dst = int'(ins[2:0]);
    s   = (src == 7) ? int'(d) : m_r[src];
    dd  = (dst == 7) ? (m_out % 256) : m_r[dst];
    v   = 0;
    case (op)
      0: v = src;
      1: begin v = (dd + s) % 256; m_carry = ((dd + s) > 255) ? 1 : 0; end
      2: v = s;
      default: v = 0;
    endcase
    if (op != 3) begin
      if (dst == 7) m_out = v; else m_r[dst] = v;
      m_zero = (v == 0) ? 1 : 0;
    end else begin
`ifdef UNIDAD_MUL_EN
      p       = dd * s;
      m_out   = p;
      if (dst != 7) m_r[dst] = p % 256;
      m_carry = ((p / 256) != 0) ? 1 : 0;
      m_zero  = (p == 0) ? 1 : 0;
`else
      p = 0;
`endif
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_out"},   int'(out_data), m_out);
    chk({tag, "_zero"},  int'(zero),     m_zero);
    chk({tag, "_carry"}, int'(carry),    m_carry);
  endtask

  // issue one instruction, wait for acceptance, then check retirement
  task automatic step(input string tag, input logic [7:0] ins, input logic [7:0] d);
    int w;
    w = 0;
    @(negedge clk);
    instr = ins; in_data = d; instr_valid = 1'b1;
    while (!instr_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_rdy_wait"}, (w < 50) ? 1 : 0, 1);
    model_exec(ins, d);
    @(negedge clk);
    instr_valid = 1'b0;
`ifdef UNIDAD_MUL_EN
    if (ins[7:6] == 2'b11) begin
      for (int k = 1; k <= 9; k++) begin
        chk({tag, "_mul_rdy"},  int'(instr_ready), 0);
        chk({tag, "_mul_done"}, int'(done), (k == 9) ? 1 : 0);
        if (k == 9) chk_outs(tag);
        @(negedge clk);
      end
      chk({tag, "_mul_rdy_back"}, int'(instr_ready), 1);
      chk({tag, "_mul_done_end"}, int'(done), 0);
      return;
    end
`endif
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_rdy"},  int'(instr_ready), 1);
    chk_outs(tag);
  endtask

  logic [7:0] b2b_ins [4];
  logic [7:0] b2b_dat [4];
  logic [7:0] r_ins;
  logic [7:0] r_dat;

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out",   int'(out_data),    0);
    chk("rst_zero",  int'(zero),        1);
    chk("rst_carry", int'(carry),       0);
    chk("rst_rdy",   int'(instr_ready), 1);
    chk("rst_done",  int'(done),        0);
    rst = 1'b0;

    // register moves
    step("ldi_r0",  8'b00_001_000, 8'h00);
    step("mov_r1",  8'b10_000_001, 8'h00);
    step("mov_r2",  8'b10_111_010, 8'hAA);
    step("mov_out", 8'b10_010_111, 8'h00);
    chk("mov_out_const", int'(out_data), 16'h00AA);
    chk("mov_out_nz",    int'(zero),     0);

    // ADD wrap: R0=FF, R1=1
    step("ld_ff",  8'b10_111_000, 8'hFF);
    step("add_wr", 8'b01_001_000, 8'h00);
    chk("add_carry_const", int'(carry), 1);
    chk("add_zero_const",  int'(zero),  1);
    step("rd_r0",  8'b10_000_111, 8'h00);
    chk("add_r0_const", int'(out_data), 0);

`ifdef UNIDAD_MUL_EN
    step("ld_r3", 8'b10_111_011, 8'hFF);
    step("mul",   8'b11_111_011, 8'hFF);
    chk("mul_out_const",   int'(out_data), 16'hFE01);
    chk("mul_carry_const", int'(carry),    1);
    step("rd_r3", 8'b10_011_111, 8'h00);
    chk("mul_r3_const", int'(out_data), 16'h0001);

    // reset 3 clks into a MUL
    step("ld_r3b", 8'b10_111_011, 8'h35);
    @(negedge clk);
    instr = 8'b11_111_011; in_data = 8'h47; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("mrst_out",   int'(out_data),    0);
    chk("mrst_zero",  int'(zero),        1);
    chk("mrst_carry", int'(carry),       0);
    chk("mrst_done",  int'(done),        0);
    chk("mrst_rdy",   int'(instr_ready), 1);
    step("mrst_rd_r3", 8'b10_011_111, 8'h00);
`else
    step("nop", 8'b11_010_001, 8'h5C);
`endif

    // back-to-back with hazards, valid held high
    b2b_ins[0] = 8'b10_111_100; b2b_dat[0] = 8'h5A;
    b2b_ins[1] = 8'b10_100_111; b2b_dat[1] = 8'h00;
    b2b_ins[2] = 8'b01_100_111; b2b_dat[2] = 8'h00;
    b2b_ins[3] = 8'b10_111_111; b2b_dat[3] = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      instr = b2b_ins[i]; in_data = b2b_dat[i]; instr_valid = 1'b1;
      model_exec(b2b_ins[i], b2b_dat[i]);
      @(negedge clk);
      chk("b2b_done", int'(done), 1);
      chk_outs("b2b");
    end
    instr_valid = 1'b0;
    chk("b2b_out_hazard", int'(out_data), 0);
    @(negedge clk);
    chk("b2b_done_end", int'(done), 0);

    // randomized instructions
    for (int n = 0; n < 60; n++) begin
      r_ins = 8'($urandom_range(0, 255));
      r_dat = 8'($urandom_range(0, 255));
      step("rnd", r_ins, r_dat);
      if ($urandom_range(0, 3) == 0) step("rnd_peek", {2'b10, r_ins[2:0], 3'b111}, r_dat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
